// File: rtl/mem_pkg.sv
// Shared main-memory constants and address helpers; the cache fill engine imports
// the same latency so both ends of the read path agree.
package mem_pkg;

  localparam int unsigned MEM_READ_LATENCY = 4;
  localparam int unsigned MEM_WORD_WIDTH   = 16;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_READ,
    REQ_WRITE
  } req_kind_e;

  // Byte address to word index; bits above the index width alias (wrap).
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                             input int unsigned index_bits);
    logic [31:0] mask;
    mask = (32'd1 << index_bits) - 32'd1;
    return (byte_addr >> 1) & mask;
  endfunction

endpackage

// File: rtl/latency_pipe.sv
// Fixed-depth {valid, data} delay line, advancing every cycle with no stall.
module latency_pipe #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [DEPTH-1:0] stage_valid
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid   = valid_q[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign stage_valid = valid_q;

endmodule

// File: rtl/memory_read_responder.sv
// Word-organised memory responder: writes land immediately, reads return a
// fixed READ_LATENCY cycles later as a one-cycle data_valid strobe.
module memory_read_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned INDEX_BITS   = 15,
  parameter int unsigned READ_LATENCY = MEM_READ_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      wr,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [MEM_WORD_WIDTH-1:0] data_in,
  output logic [MEM_WORD_WIDTH-1:0] data_out,
  output logic                      data_valid,
  output logic                      busy
);

  localparam int unsigned DEPTH_WORDS = 1 << INDEX_BITS;

  logic [MEM_WORD_WIDTH-1:0] storage [DEPTH_WORDS];
  logic [INDEX_BITS-1:0]     idx;
  logic [MEM_WORD_WIDTH-1:0] rd_word;
  logic                      rd_valid;
  logic [READ_LATENCY-1:0]   stage_valid;
  req_kind_e                 req;

  always_comb begin
    idx = INDEX_BITS'(word_index(32'(addr), INDEX_BITS));
    req = REQ_IDLE;
    if (enable) req = wr ? REQ_WRITE : REQ_READ;
  end

  // Storage has no reset; requests seen while rst_n is low are dropped here
  // and by the held-in-reset pipeline.
  always_ff @(posedge clk) begin
    if (rst_n && req == REQ_WRITE) storage[idx] <= data_in;
  end

  // Data is captured at issue, so later writes cannot alter an in-flight read.
  always_comb begin
    rd_valid = (req == REQ_READ);
    rd_word  = rd_valid ? storage[idx] : '0;
  end

  latency_pipe #(
    .DEPTH (READ_LATENCY),
    .WIDTH (MEM_WORD_WIDTH)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (rd_valid),
    .in_data     (rd_word),
    .out_valid   (data_valid),
    .out_data    (data_out),
    .stage_valid (stage_valid)
  );

  assign busy = |stage_valid;

endmodule
